// File: rtl/fft_core_param.sv
// fft_core_param: in-place radix-2 decimation-in-time FFT/IFFT engine.
// A frame is loaded bit-reversed into a register array. One butterfly per
// cycle is then computed in place, with saturation, optional per-stage
// halving and conjugated twiddles for the inverse transform.
module fft_core_param #(
  parameter int LOG2_N   = 6,
  parameter int D_WIDTH  = 16,
  parameter int TW_WIDTH = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [(1<<LOG2_N)*D_WIDTH-1:0]      in_re,
  input  logic [(1<<LOG2_N)*D_WIDTH-1:0]      in_im,
  input  logic                                inverse,
  input  logic                                scale_en,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [(1<<LOG2_N)*D_WIDTH-1:0]      out_re,
  output logic [(1<<LOG2_N)*D_WIDTH-1:0]      out_im,
  output logic                                ovf,
  output logic                                busy,
  output logic [LOG2_N-2:0]                   tw_addr,
  input  logic signed [TW_WIDTH-1:0]          tw_re,
  input  logic signed [TW_WIDTH-1:0]          tw_im
);

  localparam int N       = 1 << LOG2_N;
  localparam int TW_FRAC = TW_WIDTH - 2;
  localparam int PW      = D_WIDTH + TW_WIDTH + 2;
  localparam int SW      = D_WIDTH + 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [LOG2_N-2:0]    B_LAST = (LOG2_N-1)'(N/2 - 1);
  localparam logic [3:0]           S_LAST = 4'(LOG2_N - 1);
  localparam logic signed [PW-1:0] RND    = PW'(1 << (TW_FRAC - 1));
  localparam logic signed [SW-1:0] MAXV   = SW'((1 << (D_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MINV   = SW'(-(1 << (D_WIDTH - 1)));

  logic [1:0]              state_q, state_d;
  logic [3:0]              s_q, s_d;
  logic [LOG2_N-2:0]       b_q, b_d;
  logic                    inv_q, sc_q, ovf_q, ovf_d;
  logic signed [D_WIDTH-1:0] re_q [N];
  logic signed [D_WIDTH-1:0] im_q [N];

  logic [LOG2_N-1:0] bExt, spanBit, kMask, kVal, topIdx, botIdx;
  logic [3:0]        twShift;
  logic [LOG2_N-2:0] twIdx;

  logic signed [D_WIDTH-1:0]  xtRe, xtIm, xbRe, xbIm;
  logic signed [TW_WIDTH:0]   wRe, wImRaw, wIm;
  logic signed [PW-1:0]       prodRe, prodIm;
  logic signed [D_WIDTH+1:0]  tRe, tIm;
  logic signed [SW-1:0]       topRe, topIm, botRe, botIm;
  logic signed [D_WIDTH-1:0]  topReS, topImS, botReS, botImS;
  logic                       clipAny;
  logic                       unusedBits;

  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
    logic [LOG2_N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2_N; i++) r[i] = a[LOG2_N-1-i];
    return r;
  endfunction

  function automatic logic signed [SW-1:0] scaleV(input logic signed [SW-1:0] v,
                                                  input logic en);
    return en ? ((v + SW'(1)) >>> 1) : v;
  endfunction

  function automatic logic clipped(input logic signed [SW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [D_WIDTH-1:0] satVal(input logic signed [SW-1:0] v);
    if (v > MAXV) return MAXV[D_WIDTH-1:0];
    if (v < MINV) return MINV[D_WIDTH-1:0];
    return v[D_WIDTH-1:0];
  endfunction

  // Butterfly addressing: top/bottom indices and twiddle index from (s, b)
  always_comb begin
    bExt    = {1'b0, b_q};
    spanBit = LOG2_N'(1) << s_q;
    kMask   = spanBit - LOG2_N'(1);
    kVal    = bExt & kMask;
    topIdx  = ((bExt & ~kMask) << 1) | kVal;
    botIdx  = topIdx | spanBit;
    twShift = S_LAST - s_q;
    twIdx   = (LOG2_N-1)'(kVal) << twShift;
  end

  // Butterfly datapath: rounded complex multiply, add/sub, optional halving, saturation
  always_comb begin
    xtRe   = re_q[topIdx];
    xtIm   = im_q[topIdx];
    xbRe   = re_q[botIdx];
    xbIm   = im_q[botIdx];
    wRe    = (TW_WIDTH+1)'(tw_re);
    wImRaw = (TW_WIDTH+1)'(tw_im);
    wIm    = inv_q ? -wImRaw : wImRaw;
    prodRe = PW'(xbRe) * PW'(wRe) - PW'(xbIm) * PW'(wIm) + RND;
    prodIm = PW'(xbRe) * PW'(wIm) + PW'(xbIm) * PW'(wRe) + RND;
    tRe    = prodRe[TW_FRAC +: D_WIDTH+2];
    tIm    = prodIm[TW_FRAC +: D_WIDTH+2];
    topRe  = scaleV(SW'(xtRe) + SW'(tRe), sc_q);
    topIm  = scaleV(SW'(xtIm) + SW'(tIm), sc_q);
    botRe  = scaleV(SW'(xtRe) - SW'(tRe), sc_q);
    botIm  = scaleV(SW'(xtIm) - SW'(tIm), sc_q);
    topReS = satVal(topRe);
    topImS = satVal(topIm);
    botReS = satVal(botRe);
    botImS = satVal(botIm);
    clipAny = clipped(topRe) | clipped(topIm) | clipped(botRe) | clipped(botIm);
  end

  assign unusedBits = ^{prodRe[TW_FRAC-1:0], prodRe[PW-1:TW_FRAC+D_WIDTH+2],
                        prodIm[TW_FRAC-1:0], prodIm[PW-1:TW_FRAC+D_WIDTH+2]};

  // Next-state logic for the IDLE/RUN/DONE sequence and stage/butterfly counters
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        ovf_d = ovf_q | clipAny;
        if (b_q == B_LAST) begin
          b_d = '0;
          if (s_q == S_LAST) state_d = DONE;
          else               s_d = s_q + 4'd1;
        end else begin
          b_d = b_q + (LOG2_N-1)'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers, updated on the falling clock edge
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
      sc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
      if (state_q == IDLE && in_valid) begin
        inv_q <= inverse;
        sc_q  <= scale_en;
      end
    end
  end

  // Sample array: bit-reversed load on accept, in-place butterfly writes in RUN
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (state_q == IDLE && in_valid) begin
      for (int i = 0; i < N; i++) begin
        re_q[bitrev(LOG2_N'(i))] <= in_re[i*D_WIDTH +: D_WIDTH];
        im_q[bitrev(LOG2_N'(i))] <= in_im[i*D_WIDTH +: D_WIDTH];
      end
    end else if (state_q == RUN) begin
      re_q[topIdx] <= topReS;
      im_q[topIdx] <= topImS;
      re_q[botIdx] <= botReS;
      im_q[botIdx] <= botImS;
    end
  end

  // Output bus mirrors the array; status outputs decode the state
  always_comb begin
    for (int i = 0; i < N; i++) begin
      out_re[i*D_WIDTH +: D_WIDTH] = re_q[i];
      out_im[i*D_WIDTH +: D_WIDTH] = im_q[i];
    end
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    ovf       = ovf_q;
    tw_addr   = (state_q == RUN) ? twIdx : '0;
  end

endmodule

// File: tb/tb_fft_core_param.sv
// tb_fft_core_param: directed self-checking bench for the 64-point configuration.
module tb_fft_core_param;

  localparam int LOG2_N = 6;
  localparam int N      = 64;
  localparam int DW     = 16;
  localparam int TWW    = 10;
  localparam int M      = LOG2_N * N / 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   in_re = '0;
  logic [N*DW-1:0]   in_im = '0;
  logic              inverse = 1'b0;
  logic              scale_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N*DW-1:0]   out_re, out_im;
  logic              ovf, busy;
  logic [LOG2_N-2:0] tw_addr;
  logic signed [TWW-1:0] tw_re, tw_im;

  logic signed [TWW-1:0] twReTab [N/2];
  logic signed [TWW-1:0] twImTab [N/2];
  logic signed [DW-1:0]  stimRe [N];
  logic signed [DW-1:0]  stimIm [N];
  int                    twLog [M];
  int                    errCount = 0;
  int                    checkCount = 0;
  int                    latency;

  fft_core_param #(.LOG2_N(LOG2_N), .D_WIDTH(DW), .TW_WIDTH(TWW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im),
    .inverse(inverse), .scale_en(scale_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .ovf(ovf), .busy(busy),
    .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im)
  );

  // Free-running clock; the DUT updates on the falling edge
  always #5 clk = ~clk;

  // Combinational twiddle ROM: W_64^k scaled by 2^8
  assign tw_re = twReTab[tw_addr];
  assign tw_im = twImTab[tw_addr];

  // Build the twiddle table from cos/sin
  initial begin
    for (int k = 0; k < N/2; k++) begin
      twReTab[k] = TWW'($rtoi($floor(256.0 * $cos(2.0 * 3.14159265358979 * k / N) + 0.5)));
      twImTab[k] = TWW'($rtoi($floor(-256.0 * $sin(2.0 * 3.14159265358979 * k / N) + 0.5)));
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input longint observed,
                             input longint expected, input longint tol = 0);
    checkCount++;
    if (observed - expected > tol || expected - observed > tol) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, want %0d (tol %0d)", tag, observed, expected, tol);
    end
  endtask

  function automatic longint binRe(input int i);
    return longint'($signed(out_re[i*DW +: DW]));
  endfunction

  function automatic longint binIm(input int i);
    return longint'($signed(out_im[i*DW +: DW]));
  endfunction

  task automatic clearStim();
    for (int i = 0; i < N; i++) begin
      stimRe[i] = '0;
      stimIm[i] = '0;
    end
  endtask

  // Offer one frame, then follow it until out_valid or until abortAt butterflies
  task automatic applyStimulus(input bit inv, input bit sc, input int abortAt,
                               output int lat);
    @(posedge clk);
    checkOutput("acceptReady", longint'(in_ready), 1);
    for (int i = 0; i < N; i++) begin
      in_re[i*DW +: DW] = stimRe[i];
      in_im[i*DW +: DW] = stimIm[i];
    end
    inverse  = inv;
    scale_en = sc;
    in_valid = 1'b1;
    @(negedge clk);
    lat = 0;
    forever begin
      @(posedge clk);
      in_valid = 1'b0;
      inverse  = ~inv;
      scale_en = ~sc;
      if (busy && lat < M) twLog[lat] = int'(tw_addr);
      if (out_valid || lat == abortAt || lat >= 400) break;
      @(negedge clk);
      lat++;
    end
  endtask

  // Complete the output handshake and confirm the return to IDLE
  task automatic finishFrame();
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    out_ready = 1'b0;
    checkOutput("idleReady", longint'(in_ready), 1);
    checkOutput("idleValid", longint'(out_valid), 0);
  endtask

  task automatic checkImpulse(input string tag);
    checkOutput({tag, "Latency"}, longint'(latency), M);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%sRe%0d", tag, i), binRe(i), 256);
      checkOutput($sformatf("%sIm%0d", tag, i), binIm(i), 0);
    end
    checkOutput({tag, "Ovf"}, longint'(ovf), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    checkOutput("rstValid", longint'(out_valid), 0);
    checkOutput("rstBusy", longint'(busy), 0);
    checkOutput("rstOvf", longint'(ovf), 0);
    checkOutput("rstTwAddr", longint'(tw_addr), 0);
    checkOutput("rstOut0", binRe(0), 0);
    rst = 1'b1;
    @(posedge clk);
    checkOutput("rstReady", longint'(in_ready), 1);

    // Impulse
    clearStim();
    stimRe[0] = 16'sd256;
    applyStimulus(1'b0, 1'b0, -1, latency);
    checkImpulse("imp");
    finishFrame();

    // DC, unscaled and scaled
    for (int sc = 0; sc < 2; sc++) begin
      clearStim();
      for (int i = 0; i < N; i++) stimRe[i] = 16'sd100;
      applyStimulus(1'b0, sc[0], -1, latency);
      checkOutput($sformatf("dc%0dLatency", sc), longint'(latency), M);
      checkOutput($sformatf("dc%0dBin0", sc), binRe(0), (sc == 0) ? 6400 : 100);
      for (int i = 1; i < N; i++) begin
        checkOutput($sformatf("dc%0dRe%0d", sc, i), binRe(i), 0);
        checkOutput($sformatf("dc%0dIm%0d", sc, i), binIm(i), 0);
      end
      checkOutput($sformatf("dc%0dOvf", sc), longint'(ovf), 0);
      finishFrame();
    end

    // Saturation, unscaled and scaled
    for (int sc = 0; sc < 2; sc++) begin
      clearStim();
      for (int i = 0; i < N; i++) stimRe[i] = 16'sd32767;
      applyStimulus(1'b0, sc[0], -1, latency);
      checkOutput($sformatf("sat%0dBin0", sc), binRe(0), 32767);
      checkOutput($sformatf("sat%0dOvf", sc), longint'(ovf), (sc == 0) ? 1 : 0);
      if (sc == 1) begin
        for (int i = 1; i < N; i++) checkOutput($sformatf("sat1Re%0d", i), binRe(i), 0);
      end
      finishFrame();
    end

    // Inverse mode with a delayed impulse
    for (int inv = 0; inv < 2; inv++) begin
      clearStim();
      stimRe[1] = 16'sd256;
      applyStimulus(inv[0], 1'b0, -1, latency);
      checkOutput($sformatf("inv%0dBin16Re", inv), binRe(16), 0, 2);
      checkOutput($sformatf("inv%0dBin16Im", inv), binIm(16), (inv == 0) ? -256 : 256, 2);
      for (int j = 0; j < N/2; j++)
        checkOutput($sformatf("inv%0dTw%0d", inv, j), longint'(twLog[M - N/2 + j]), j);
      finishFrame();
    end

    // Backpressure in DONE with in_valid pulses
    clearStim();
    for (int i = 0; i < N; i++) stimRe[i] = 16'sd100;
    applyStimulus(1'b0, 1'b0, -1, latency);
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid;
      in_re[DW-1:0] = DW'(c * 7 + 1);
      @(negedge clk);
      @(posedge clk);
      checkOutput($sformatf("bpValid%0d", c), longint'(out_valid), 1);
      checkOutput($sformatf("bpReady%0d", c), longint'(in_ready), 0);
      checkOutput($sformatf("bpBusy%0d", c), longint'(busy), 0);
      checkOutput($sformatf("bpBin0_%0d", c), binRe(0), 6400);
      checkOutput($sformatf("bpBin1_%0d", c), binRe(1), 0);
      checkOutput($sformatf("bpOvf%0d", c), longint'(ovf), 0);
    end
    in_valid = 1'b0;
    finishFrame();
    checkOutput("bpIdleBusy", longint'(busy), 0);

    // Reset in the middle of RUN
    clearStim();
    stimRe[0] = 16'sd256;
    applyStimulus(1'b0, 1'b0, 50, latency);
    checkOutput("abortReached", longint'(latency), 50);
    checkOutput("abortBusyBefore", longint'(busy), 1);
    rst = 1'b0;
    #1;
    checkOutput("abortBusy", longint'(busy), 0);
    checkOutput("abortValid", longint'(out_valid), 0);
    checkOutput("abortOvf", longint'(ovf), 0);
    checkOutput("abortTwAddr", longint'(tw_addr), 0);
    for (int i = 0; i < N; i++) checkOutput($sformatf("abortRe%0d", i), binRe(i), 0);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    checkOutput("abortReady", longint'(in_ready), 1);
    applyStimulus(1'b0, 1'b0, -1, latency);
    checkImpulse("post");
    finishFrame();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
